// File: rtl/periph_bus_ctrl.sv
// Single-master peripheral bus controller: decodes one CPU request against the
// BOOTROM/UART/PLIC windows, forwards it and returns the peripheral response.

package config_pkg;

    typedef struct packed {
        logic [31:0] BOOTROM_BASE;
        logic [31:0] BOOTROM_RANGE;
        logic        BOOTROM_SUPPORTED;
        logic        BOOTROM_PRELOAD;
        logic [31:0] UART_BASE;
        logic [31:0] UART_RANGE;
        logic        UART_SUPPORTED;
        logic [31:0] PLIC_BASE;
        logic [31:0] PLIC_RANGE;
        logic        PLIC_SUPPORTED;
    } config_t;

    localparam config_t DEFAULT_CFG = '{
        BOOTROM_BASE:      32'h0000_0000,
        BOOTROM_RANGE:     32'h0000_FFFF,
        BOOTROM_SUPPORTED: 1'b1,
        BOOTROM_PRELOAD:   1'b0,
        UART_BASE:         32'h1000_0000,
        UART_RANGE:        32'h0000_00FF,
        UART_SUPPORTED:    1'b1,
        PLIC_BASE:         32'h0C00_0000,
        PLIC_RANGE:        32'h03FF_FFFF,
        PLIC_SUPPORTED:    1'b1
    };

endpackage

module periph_bus_ctrl #(
    parameter config_pkg::config_t CFG            = config_pkg::DEFAULT_CFG,
    parameter int unsigned         TIMEOUT_CYCLES = 255
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    // master side
    input  logic             m_req_valid_i,
    output logic             m_req_ready_o,
    input  logic [31:0]      m_addr_i,
    input  logic             m_we_i,
    input  logic [31:0]      m_wdata_i,
    input  logic [3:0]       m_wstrb_i,
    output logic             m_rsp_valid_o,
    output logic [31:0]      m_rdata_o,
    output logic             m_err_o,
    // peripheral side
    output logic [2:0]       s_sel_o,
    output logic             s_req_valid_o,
    input  logic [2:0]       s_req_ready_i,
    output logic [31:0]      s_addr_o,
    output logic             s_we_o,
    output logic [31:0]      s_wdata_o,
    output logic [3:0]       s_wstrb_o,
    input  logic [2:0]       s_rsp_valid_i,
    input  logic [2:0][31:0] s_rdata_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_REQ,
        ST_WAIT,
        ST_RSP
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        ready_q;
    logic [31:0] addr_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [2:0]  sel_q;
    logic [31:0] offs_q;
    logic [15:0] cnt_q;
    logic [31:0] rdata_q;
    logic        err_q;

    // Inclusive window check done in 33 bits so BASE+RANGE never wraps.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] range);
        logic [32:0] lo, hi, a;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = {1'b0, base} + {1'b0, range};
        return (a >= lo) && (a <= hi);
    endfunction

    logic hit_boot, hit_uart, hit_plic;
    assign hit_boot = CFG.BOOTROM_SUPPORTED && in_window(addr_q, CFG.BOOTROM_BASE, CFG.BOOTROM_RANGE);
    assign hit_uart = CFG.UART_SUPPORTED    && in_window(addr_q, CFG.UART_BASE,    CFG.UART_RANGE);
    assign hit_plic = CFG.PLIC_SUPPORTED    && in_window(addr_q, CFG.PLIC_BASE,    CFG.PLIC_RANGE);

    logic [2:0]  dec_sel;
    logic [31:0] dec_offs;
    logic        dec_err;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        dec_sel  = 3'b000;
        dec_offs = '0;
        dec_err  = 1'b0;
        if (hit_boot) begin
            if (we_q && !CFG.BOOTROM_PRELOAD) begin
                dec_err = 1'b1;
            end else begin
                dec_sel  = 3'b001;
                dec_offs = addr_q - CFG.BOOTROM_BASE;
            end
        end else if (hit_uart) begin
            dec_sel  = 3'b010;
            dec_offs = addr_q - CFG.UART_BASE;
        end else if (hit_plic) begin
            dec_sel  = 3'b100;
            dec_offs = addr_q - CFG.PLIC_BASE;
        end else begin
            dec_err = 1'b1;
        end
    end

    // sel_q is one-hot, so masking with it picks the selected peripheral.
    logic        req_hit, rsp_hit, timeout;
    logic [31:0] rsp_data;
    assign req_hit = |(s_req_ready_i & sel_q);
    assign rsp_hit = |(s_rsp_valid_i & sel_q);
    assign timeout = (cnt_q == CNT_LAST);

    always_comb begin
        rsp_data = '0;
        for (int i = 0; i < 3; i++) begin
            if (sel_q[i]) rsp_data = rsp_data | s_rdata_i[i];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (m_req_valid_i) state_d = ST_DECODE;
            ST_DECODE: state_d = dec_err ? ST_RSP : ST_REQ;
            ST_REQ: begin
                if (timeout)      state_d = ST_RSP;
                else if (req_hit) state_d = ST_WAIT;
            end
            // A response arriving on the timeout cycle still wins.
            ST_WAIT:   if (rsp_hit || timeout) state_d = ST_RSP;
            ST_RSP:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            sel_q   <= '0;
            offs_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == ST_IDLE);
            unique case (state_q)
                ST_IDLE: begin
                    if (m_req_valid_i) begin
                        addr_q  <= m_addr_i;
                        we_q    <= m_we_i;
                        wdata_q <= m_wdata_i;
                        wstrb_q <= m_wstrb_i;
                    end
                end
                ST_DECODE: begin
                    cnt_q   <= '0;
                    rdata_q <= '0;
                    err_q   <= dec_err;
                    if (!dec_err) begin
                        sel_q  <= dec_sel;
                        offs_q <= dec_offs;
                    end
                end
                ST_REQ: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (timeout) err_q <= 1'b1;
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (rsp_hit) begin
                        rdata_q <= we_q ? '0 : rsp_data;
                        err_q   <= 1'b0;
                    end else if (timeout) begin
                        err_q <= 1'b1;
                    end
                end
                ST_RSP:  sel_q <= '0;
                default: ;
            endcase
        end
    end

    assign m_req_ready_o = ready_q;
    assign m_rsp_valid_o = (state_q == ST_RSP);
    assign m_rdata_o     = m_rsp_valid_o ? rdata_q : '0;
    assign m_err_o       = m_rsp_valid_o & err_q;

    assign s_sel_o       = sel_q;
    assign s_req_valid_o = (state_q == ST_REQ);
    assign s_addr_o      = offs_q;
    assign s_we_o        = we_q;
    assign s_wdata_o     = wdata_q;
    assign s_wstrb_o     = wstrb_q;

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Directed bench for periph_bus_ctrl: instance a uses the default map, instance b
// enables BOOTROM preload and disables the UART; both time out after 8 cycles.

module tb_periph_bus_ctrl;

    localparam config_pkg::config_t CFG_A = config_pkg::DEFAULT_CFG;
    localparam config_pkg::config_t CFG_B = '{
        BOOTROM_BASE:      32'h0000_0000,
        BOOTROM_RANGE:     32'h0000_FFFF,
        BOOTROM_SUPPORTED: 1'b1,
        BOOTROM_PRELOAD:   1'b1,
        UART_BASE:         32'h1000_0000,
        UART_RANGE:        32'h0000_00FF,
        UART_SUPPORTED:    1'b0,
        PLIC_BASE:         32'h0C00_0000,
        PLIC_RANGE:        32'h03FF_FFFF,
        PLIC_SUPPORTED:    1'b1
    };

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic             m_req_valid = 1'b0;
    logic [31:0]      m_addr = '0;
    logic             m_we = 1'b0;
    logic [31:0]      m_wdata = '0;
    logic [3:0]       m_wstrb = '0;
    logic [2:0]       s_req_ready = '0;
    logic [2:0]       s_rsp_valid = '0;
    logic [2:0][31:0] s_rdata = '0;

    logic        a_req_ready, a_rsp_valid, a_err, a_s_req_valid, a_s_we;
    logic [31:0] a_rdata, a_s_addr, a_s_wdata;
    logic [2:0]  a_sel;
    logic [3:0]  a_s_wstrb;
    logic        b_req_ready, b_rsp_valid, b_err, b_s_req_valid, b_s_we;
    logic [31:0] b_rdata, b_s_addr, b_s_wdata;
    logic [2:0]  b_sel;
    logic [3:0]  b_s_wstrb;

    int n_tests = 0;
    int n_fail  = 0;

    periph_bus_ctrl #(.CFG(CFG_A), .TIMEOUT_CYCLES(8)) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .m_req_valid_i(m_req_valid), .m_req_ready_o(a_req_ready),
        .m_addr_i(m_addr), .m_we_i(m_we), .m_wdata_i(m_wdata), .m_wstrb_i(m_wstrb),
        .m_rsp_valid_o(a_rsp_valid), .m_rdata_o(a_rdata), .m_err_o(a_err),
        .s_sel_o(a_sel), .s_req_valid_o(a_s_req_valid), .s_req_ready_i(s_req_ready),
        .s_addr_o(a_s_addr), .s_we_o(a_s_we), .s_wdata_o(a_s_wdata), .s_wstrb_o(a_s_wstrb),
        .s_rsp_valid_i(s_rsp_valid), .s_rdata_i(s_rdata)
    );

    periph_bus_ctrl #(.CFG(CFG_B), .TIMEOUT_CYCLES(8)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .m_req_valid_i(m_req_valid), .m_req_ready_o(b_req_ready),
        .m_addr_i(m_addr), .m_we_i(m_we), .m_wdata_i(m_wdata), .m_wstrb_i(m_wstrb),
        .m_rsp_valid_o(b_rsp_valid), .m_rdata_o(b_rdata), .m_err_o(b_err),
        .s_sel_o(b_sel), .s_req_valid_o(b_s_req_valid), .s_req_ready_i(s_req_ready),
        .s_addr_o(b_s_addr), .s_we_o(b_s_we), .s_wdata_o(b_s_wdata), .s_wstrb_o(b_s_wstrb),
        .s_rsp_valid_i(s_rsp_valid), .s_rdata_i(s_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request; returns #1 after the accepting edge N.
    task automatic issue(input logic [31:0] addr, input logic we,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
        m_req_valid = 1'b1;
        m_addr      = addr;
        m_we        = we;
        m_wdata     = wdata;
        m_wstrb     = wstrb;
        step();
        m_req_valid = 1'b0;
    endtask

    task automatic settle();
        s_req_ready = '0;
        s_rsp_valid = '0;
        for (int i = 0; i < 40 && !(a_req_ready && b_req_ready); i++) step();
        check("settle_a_ready", {31'd0, a_req_ready}, 32'd1);
        check("settle_b_ready", {31'd0, b_req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        s_rdata[0] = 32'h0000_DEAD;
        s_rdata[1] = 32'h0000_00A5;
        s_rdata[2] = 32'h1234_5678;

        // Reset state: ready stays low while reset is held.
        repeat (3) step();
        check("rst_ready",     {31'd0, a_req_ready},   32'd0);
        check("rst_rsp_valid", {31'd0, a_rsp_valid},   32'd0);
        check("rst_sel",       {29'd0, a_sel},         32'd0);
        check("rst_s_req",     {31'd0, a_s_req_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("ready_after_rst", {31'd0, a_req_ready}, 32'd1);

        // UART read, best-case latency: response in cycle after edge N+3.
        s_req_ready = 3'b010;
        s_rsp_valid = 3'b010;
        issue(32'h1000_0004, 1'b0, 32'h0, 4'h0);
        check("t1_busy",    {31'd0, a_req_ready}, 32'd0);
        step();
        check("t1_sel",     {29'd0, a_sel},         32'h2);
        check("t1_s_addr",  a_s_addr,               32'h4);
        check("t1_s_req",   {31'd0, a_s_req_valid}, 32'd1);
        check("t1_b_nouart", {30'd0, b_rsp_valid, b_err}, 32'h3);
        step();
        check("t1_no_early", {31'd0, a_rsp_valid}, 32'd0);
        step();
        check("t1_rsp",     {31'd0, a_rsp_valid}, 32'd1);
        check("t1_rdata",   a_rdata,              32'hA5);
        check("t1_err",     {31'd0, a_err},       32'd0);
        step();
        check("t1_idle_ready", {31'd0, a_req_ready}, 32'd1);
        check("t1_sel_clr",    {29'd0, a_sel},       32'd0);
        check("t1_rsp_once",   {31'd0, a_rsp_valid}, 32'd0);
        settle();

        // Unmapped read: error two cycles after acceptance, no peripheral request.
        s_req_ready = 3'b111;
        s_rsp_valid = 3'b111;
        issue(32'h2000_0000, 1'b0, 32'h0, 4'h0);
        check("t2_no_s_req0", {31'd0, a_s_req_valid}, 32'd0);
        step();
        check("t2_rsp_err",   {30'd0, a_rsp_valid, a_err}, 32'h3);
        check("t2_rdata",     a_rdata,                     32'h0);
        check("t2_no_s_req1", {31'd0, a_s_req_valid},      32'd0);
        check("t2_b_err",     {30'd0, b_rsp_valid, b_err}, 32'h3);
        settle();

        // BOOTROM write: rejected without preload, forwarded with it.
        s_req_ready = 3'b001;
        s_rsp_valid = 3'b001;
        issue(32'h0000_0000, 1'b1, 32'hCAFE_F00D, 4'h3);
        step();
        check("t3_a_err",    {30'd0, a_rsp_valid, a_err}, 32'h3);
        check("t3_b_sel",    {29'd0, b_sel},              32'h1);
        check("t3_b_s_req",  {31'd0, b_s_req_valid},      32'd1);
        check("t3_b_we",     {31'd0, b_s_we},             32'd1);
        check("t3_b_wdata",  b_s_wdata,                   32'hCAFE_F00D);
        check("t3_b_wstrb",  {28'd0, b_s_wstrb},          32'h3);
        step();
        step();
        check("t3_b_rsp",    {30'd0, b_rsp_valid, b_err}, 32'h2);
        check("t3_b_rdata0", b_rdata,                     32'h0);
        settle();

        // PLIC never ready: error exactly 8 cycles after REQ entry at edge N+1.
        issue(32'h0C00_0010, 1'b0, 32'h0, 4'h0);
        step();
        check("t4_sel",    {29'd0, a_sel}, 32'h4);
        check("t4_s_addr", a_s_addr,       32'h10);
        repeat (7) step();
        check("t4_wait_rsp",   {31'd0, a_rsp_valid},   32'd0);
        check("t4_wait_s_req", {31'd0, a_s_req_valid}, 32'd1);
        step();
        check("t4_to_err",   {30'd0, a_rsp_valid, a_err}, 32'h3);
        check("t4_to_rdata", a_rdata,                     32'h0);
        check("t4_s_req_dn", {31'd0, a_s_req_valid},      32'd0);
        check("t4_b_to_err", {30'd0, b_rsp_valid, b_err}, 32'h3);
        step();
        check("t4_ready", {31'd0, a_req_ready}, 32'd1);
        settle();

        // Window boundaries: BASE+RANGE hits, BASE+RANGE+1 misses.
        s_rdata[1]  = 32'h0000_005A;
        s_req_ready = 3'b010;
        s_rsp_valid = 3'b010;
        issue(32'h1000_00FF, 1'b0, 32'h0, 4'h0);
        step();
        check("t5_top_sel",  {29'd0, a_sel}, 32'h2);
        check("t5_top_addr", a_s_addr,       32'hFF);
        step();
        step();
        check("t5_top_rsp",   {30'd0, a_rsp_valid, a_err}, 32'h2);
        check("t5_top_rdata", a_rdata,                     32'h5A);
        settle();
        s_req_ready = 3'b010;
        s_rsp_valid = 3'b010;
        issue(32'h1000_0100, 1'b0, 32'h0, 4'h0);
        step();
        check("t5_over_err", {30'd0, a_rsp_valid, a_err}, 32'h3);
        check("t5_over_sel", {29'd0, a_sel},              32'h0);
        settle();

        // Response on the timeout cycle wins: ready seen at edge N+8 (count 6),
        // response at edge N+9 where the count equals TIMEOUT_CYCLES-1.
        issue(32'h0C00_0020, 1'b0, 32'h0, 4'h0);
        repeat (7) step();
        s_req_ready = 3'b100;
        s_rsp_valid = 3'b100;
        step();
        check("t7_in_wait", {31'd0, a_s_req_valid}, 32'd0);
        check("t7_no_rsp",  {31'd0, a_rsp_valid},   32'd0);
        step();
        check("t7_rsp_wins", {30'd0, a_rsp_valid, a_err}, 32'h2);
        check("t7_rdata",    a_rdata,                     32'h1234_5678);
        settle();

        // Reset during WAIT drops everything at once and never responds.
        s_rdata[1]  = 32'h0000_00A5;
        s_req_ready = 3'b010;
        issue(32'h1000_0008, 1'b1, 32'h1357_9BDF, 4'hF);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_ready", {31'd0, a_req_ready},   32'd0);
        check("t6_rst_rsp",   {31'd0, a_rsp_valid},   32'd0);
        check("t6_rst_sel",   {29'd0, a_sel},         32'd0);
        check("t6_rst_s_req", {31'd0, a_s_req_valid}, 32'd0);
        check("t6_rst_addr",  a_s_addr,               32'd0);
        check("t6_rst_we",    {31'd0, a_s_we},        32'd0);
        check("t6_rst_wdata", a_s_wdata,              32'd0);
        s_rsp_valid = 3'b010;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_hold_no_rsp", {31'd0, a_rsp_valid}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("t6_rel_ready",  {31'd0, a_req_ready}, 32'd1);
        check("t6_rel_no_rsp", {31'd0, a_rsp_valid}, 32'd0);
        issue(32'h1000_000C, 1'b0, 32'h0, 4'h0);
        step();
        step();
        step();
        check("t6_after_rsp",   {30'd0, a_rsp_valid, a_err}, 32'h2);
        check("t6_after_rdata", a_rdata,                     32'hA5);
        settle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
